// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, RAM status codes, arbiter states and
// starvation-limit settings for the optional ARB_FAIRNESS_EN build.
package cpu_types_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned STARVE_W     = $clog2(STARVE_LIMIT + 1);

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Define ARB_FAIRNESS_EN to bound instruction starvation under data pressure.
module memory_arbiter
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  word_t       iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  word_t       daddr,
  input  word_t       dstore,
  output logic        iwait,
  output logic        dwait,
  output word_t       iload,
  output word_t       dload,
  output logic        ramREN,
  output logic        ramWEN,
  output word_t       ramaddr,
  output word_t       ramstore,
  input  word_t       ramload,
  input  logic [1:0]  ramstate
);

  arb_state_t state, next_state;
  logic       dreq;
  logic       force_i;
  logic       ram_done;

  assign dreq     = dREN | dWEN;
  assign ram_done = (ramstate_t'(ramstate) == ACCESS);
  assign iload    = ramload;
  assign dload    = ramload;

`ifdef ARB_FAIRNESS_EN
  logic [STARVE_W-1:0] starve_cnt;

  // Once data has won STARVE_LIMIT times over a waiting fetch, the fetch goes next.
  assign force_i = iREN && (starve_cnt == STARVE_W'(STARVE_LIMIT));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        if (!iREN || next_state == IGRANT)
          starve_cnt <= '0;
        else if (next_state == DGRANT && starve_cnt != STARVE_W'(STARVE_LIMIT))
          starve_cnt <= starve_cnt + STARVE_W'(1);
      end
    end
  end
`else
  assign force_i = 1'b0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end
`endif

  // Strobes follow the live request, so a withdrawn or reset grant drops them at once.
  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    case (state)
      IDLE: begin
        if (dreq && !force_i) next_state = DGRANT;
        else if (iREN)        next_state = IGRANT;
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          next_state = IDLE;
        end else if (ram_done) begin
          iwait      = 1'b0;
          next_state = IDLE;
        end
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!dreq) begin
          next_state = IDLE;
        end else if (ram_done) begin
          dwait      = 1'b0;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Single-port memory arbiter between the CPU's instruction-fetch and data-access request streams and the shared RAM. It grants one requester at a time and holds that request on the RAM port until the RAM reports ACCESS. It returns a one-cycle completion (wait low) to the granted side. It sits between the datapath/request unit (or caches) and the RAM model, and is the only driver of the RAM control port.

## Interface
- STARVE_LIMIT, 4: maximum consecutive data grants while an instruction request is pending (used only with ARB_FAIRNESS_EN).
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request; held until iwait low.
- iaddr  in  32  instruction address.
- dREN  in  1  data read request; held until dwait low.
- dWEN  in  1  data write request; held until dwait low.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- iwait  out  1  low for exactly one cycle when the instruction access completes.
- dwait  out  1  low for exactly one cycle when the data access completes.
- iload  out  32  ramload passthrough.
- dload  out  32  ramload passthrough.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- States: IDLE, IGRANT, DGRANT.
- IDLE: all ram* outputs are 0, and iwait and dwait are 1.
  - At the clock edge, if dREN|dWEN, go to DGRANT.
  - Else, if iREN, go to IGRANT.
  - Else, stay in IDLE.
- DGRANT: drive ramaddr=daddr and ramstore=dstore.
  - If dWEN, drive ramWEN=1 and ramREN=0. dWEN wins when dREN and dWEN are both high.
  - Else, drive ramREN=1.
- IGRANT: drive ramREN=1 and ramaddr=iaddr. ramWEN stays 0 and ramstore is 0.
- Completion: in a grant state, when ramstate==ACCESS, the granted side's wait is driven low combinationally in that same cycle. The next state is IDLE.
- BUSY, FREE or ERROR in a grant state: stay in the grant state and hold wait high. ERROR is retried indefinitely; it is never reported.
- Withdrawal: if the granted request drops before ACCESS, go to IDLE at the next edge.
  - The ram* strobes follow the live request in that cycle, so they are 0.
  - No completion is signalled.
- Addresses and store data are not latched. The requester must hold them stable until its wait goes low.
- The non-granted side's wait stays 1 throughout.
- Default priority is strict data over instruction.

## Timing
- Reset state is IDLE. Reset values: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
- Reset asserted mid-transaction aborts immediately. The RAM strobes drop asynchronously.
- Minimum latency is request at cycle 0, strobe at cycle 1, and wait low at cycle 1 if the RAM returns ACCESS immediately.
- Every transaction costs at least one IDLE cycle. Back-to-back requests from the same side are therefore separated by at least one cycle with strobes low.
- A request held after wait low is treated as a new request in the following IDLE cycle.
- When both sides request in the same IDLE cycle, data is granted. The instruction side waits, with iwait held 1, until the next IDLE.
- iload and dload are pure combinational passthroughs of ramload. They are valid only in the cycle the matching wait is low.

## Configuration
- ARB_FAIRNESS_EN defined: a saturating counter, $clog2(STARVE_LIMIT+1) bits wide, tracks starvation.
  - It counts DGRANT entries taken while iREN is high.
  - When it reaches STARVE_LIMIT, the next IDLE decision with iREN high goes to IGRANT, even if dREN or dWEN is high.
  - The counter clears on any IGRANT entry, and in any IDLE cycle with iREN low.
  - Reset value is 0.
- ARB_FAIRNESS_EN undefined: strict data priority. The counter is absent.

## Structure
- The ramstate_t enum (FREE, BUSY, ACCESS, ERROR) and the arb_state_t enum (IDLE, IGRANT, DGRANT) belong in cpu_types_pkg. word_t (32-bit) also comes from cpu_types_pkg.
- The port list is grouped in a shared interface header, e.g. a memory arbiter interface with arb and tb modports.
- One sub-module is optional: arb_fairness_ctr, holding the starvation counter and its "force instruction" output, instantiated only under ARB_FAIRNESS_EN.
- Otherwise the block is a single module with one always_ff for state (and the counter) and one always_comb for next-state and outputs.

## Test plan
- Reset check: pulse nRST low mid-DGRANT with ramWEN=1.
  - Required: ramWEN=0, dwait=1 and iwait=1 immediately.
  - Required: state is IDLE after release.
- Instruction read: iREN=1, iaddr=0x40. The RAM returns BUSY for 2 cycles, then ACCESS with ramload=0xDEADBEEF.
  - Required: ramREN=1 and ramaddr=0x40 from cycle 1.
  - Required: iwait=0 only in cycle 3, with iload=0xDEADBEEF.
  - Required: strobes are 0 in cycle 4.
- Simultaneous requests: iREN=1, dWEN=1, daddr=0x80, dstore=0x1234.
  - Required: the write completes first, with ramWEN=1 and ramstore=0x1234.
  - Required: the instruction read is granted after one IDLE cycle.
  - Required: iwait stays 1 during the write.
- Withdrawal: dREN drops while ramstate=BUSY.
  - Required: no dwait pulse, ramREN=0, and state returns to IDLE.
  - Required: a pending iREN is granted next.
- ERROR retry: ramstate=ERROR for 5 cycles, then ACCESS.
  - Required: the request is held unchanged for 5 cycles.
  - Required: a single wait-low pulse on ACCESS.
- Fairness: with ARB_FAIRNESS_EN and STARVE_LIMIT=4, hold iREN and dREN high continuously with immediate ACCESS.
  - Required: the grant pattern is D,D,D,D,I repeating.
  - Required: without the macro, the instruction side is never granted.
